// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test engine: writes NUM_WORDS pattern words from BASE_ADDR, reads them back,
// and reports pass/fail, saturating error count and the first failing address/data.
module sdram_pattern_tester #(
  parameter int               ADDR_W         = 25,
  parameter int               DATA_W         = 16,
  parameter int               NUM_WORDS      = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 25'h100000,
  parameter int               STARTUP_CYCLES = 50000000,
  parameter int               TIMEOUT_CYCLES = 4096,
  parameter int               ERR_W          = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  output logic              start_write,
  output logic              start_read,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              operation_done,
  input  logic              busy,
  output logic              ready,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [3:0]        state_code
);

  localparam int IDX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int ROT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SU_W  = $clog2(STARTUP_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [ROT_W-1:0] LAST_ROT = ROT_W'(DATA_W - 1);
  localparam logic [SU_W-1:0]  LAST_SU  = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_STARTUP  = 4'd0,
    S_IDLE     = 4'd1,
    S_WR_ISSUE = 4'd2,
    S_WR_WAIT  = 4'd3,
    S_RD_ISSUE = 4'd4,
    S_RD_WAIT  = 4'd5,
    S_DONE     = 4'd6
  } state_t;

  state_t              state, state_next;
  logic [SU_W-1:0]     su_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [IDX_W-1:0]    idx;
  logic [ROT_W-1:0]    rot;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   pat_q;
  logic [DATA_W-1:0]   expected;
  logic [2*DATA_W-1:0] rot_word;
  logic                last_word;
  logic                to_hit;
  logic                mismatch;

  assign last_word = (idx == LAST_IDX);
  assign to_hit    = (to_cnt == LAST_TO);
  assign mismatch  = (read_data != expected);

  // rot tracks idx mod DATA_W incrementally so no divider is needed
  always_comb begin
    rot_word = {pat_q, pat_q} << rot;
    unique case (mode_q)
      2'b00:   expected = pat_q;
      2'b01:   expected = pat_q ^ idx[DATA_W-1:0];
      2'b10:   expected = DATA_W'(1) << rot;
      default: expected = rot_word[2*DATA_W-1 -: DATA_W];
    endcase
  end

  assign address    = BASE_ADDR + idx[ADDR_W-1:0];
  assign write_data = expected;
  assign ready      = (state == S_IDLE);
  assign running    = (state == S_WR_ISSUE) || (state == S_WR_WAIT) ||
                      (state == S_RD_ISSUE) || (state == S_RD_WAIT);
  assign state_code = state;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_STARTUP;
    else                state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_write = 1'b0;
    start_read  = 1'b0;
    unique case (state)
      S_STARTUP:  if (su_cnt == LAST_SU) state_next = S_IDLE;
      S_IDLE:     if (start) state_next = S_WR_ISSUE;
      S_WR_ISSUE: if (!busy) begin
                    start_write = 1'b1;
                    state_next  = S_WR_WAIT;
                  end
      S_WR_WAIT:  if (operation_done) state_next = last_word ? S_RD_ISSUE : S_WR_ISSUE;
                  else if (to_hit)    state_next = S_DONE;
      S_RD_ISSUE: if (!busy) begin
                    start_read = 1'b1;
                    state_next = S_RD_WAIT;
                  end
      S_RD_WAIT:  if (operation_done) state_next = last_word ? S_DONE : S_RD_ISSUE;
                  else if (to_hit)    state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_STARTUP;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      su_cnt         <= '0;
      to_cnt         <= '0;
      idx            <= '0;
      rot            <= '0;
      mode_q         <= '0;
      pat_q          <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      unique case (state)
        S_STARTUP: su_cnt <= su_cnt + SU_W'(1);
        S_IDLE: if (start) begin
          mode_q         <= mode;
          pat_q          <= pattern;
          done           <= 1'b0;
          pass           <= 1'b0;
          timeout        <= 1'b0;
          err_count      <= '0;
          first_err_addr <= '0;
          first_err_data <= '0;
          idx            <= '0;
          rot            <= '0;
        end
        S_WR_ISSUE, S_RD_ISSUE: to_cnt <= '0;
        S_WR_WAIT, S_RD_WAIT: begin
          if (operation_done) begin
            if (state == S_RD_WAIT && mismatch) begin
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
              if (err_count == '0) begin
                first_err_addr <= address;
                first_err_data <= read_data;
              end
            end
            if (!last_word) begin
              idx <= idx + IDX_W'(1);
              rot <= (rot == LAST_ROT) ? '0 : rot + ROT_W'(1);
            end else if (state == S_WR_WAIT) begin
              idx <= '0;
              rot <= '0;
            end else begin
              done <= 1'b1;
              pass <= (err_count == '0) && !mismatch;
            end
          end else if (to_hit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester: vector table of full passes against a
// behavioural SDRAM model, plus startup, busy-stall and mid-pass reset sequences.
`timescale 1ns/1ps
module tb_sdram_pattern_tester;
  localparam int ADDR_W = 25, DATA_W = 16, NW = 20, SU = 10, TO = 16, ERR_W = 2;
  localparam logic [24:0] BASE = 25'h100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, start = 1'b0, busy = 1'b0, operation_done = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] pattern = 16'h0, read_data = 16'h0;
  logic        start_write, start_read, ready, running, done, pass, timeout;
  logic [24:0] address, first_err_addr;
  logic [15:0] write_data, first_err_data;
  logic [1:0]  err_count;
  logic [3:0]  state_code;

  sdram_pattern_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NW), .BASE_ADDR(BASE),
    .STARTUP_CYCLES(SU), .TIMEOUT_CYCLES(TO), .ERR_W(ERR_W)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .mode(mode), .pattern(pattern),
    .start_write(start_write), .start_read(start_read), .address(address),
    .write_data(write_data), .read_data(read_data), .operation_done(operation_done),
    .busy(busy), .ready(ready), .running(running), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .state_code(state_code)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_word(input logic [1:0] m, input logic [15:0] p, input int i);
    int r;
    r = i % 16;
    case (m)
      2'd0:    return p;
      2'd1:    return p ^ 16'(i);
      2'd2:    return 16'(1) << r;
      default: return (p << r) | (p >> (16 - r));
    endcase
  endfunction

  // SDRAM model: requests observed on the falling edge, completion after lat cycles
  int          wr_n = 0, rd_n = 0, lat = 1, drop_wr = -1, drop_rd = -1, flip_lo = 0, flip_n = 0;
  int          pend = 0, pend_idx = 0;
  bit          pend_rd = 1'b0;
  logic [24:0] pend_addr = '0;
  logic [1:0]  cur_mode = 2'd0;
  logic [15:0] cur_pat = 16'h0;
  logic [15:0] mem [0:NW-1];

  always @(negedge clk) begin
    operation_done = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          chk("addr_hold", 32'(address), 32'(pend_addr));
          if (pend_rd)
            read_data = ((pend_idx < NW) ? mem[pend_idx] : 16'hDEAD) ^
                        ((pend_idx >= flip_lo && pend_idx < flip_lo + flip_n) ? 16'h0001 : 16'h0000);
          operation_done = 1'b1;
        end
      end
      if (start_write || start_read) begin
        chk("req_excl", 32'(start_write & start_read), 32'd0);
        chk("req_busy", 32'(busy), 32'd0);
        if (start_write) begin
          chk("wr_addr", 32'(address), 32'(BASE + 25'(wr_n)));
          chk("wr_data", 32'(write_data), 32'(exp_word(cur_mode, cur_pat, wr_n)));
          if (wr_n < NW) mem[wr_n] = write_data;
          if (wr_n != drop_wr) begin pend = lat; pend_rd = 1'b0; pend_addr = address; end
          wr_n++;
        end else begin
          chk("rd_addr", 32'(address), 32'(BASE + 25'(rd_n)));
          if (rd_n != drop_rd) begin pend = lat; pend_rd = 1'b1; pend_idx = rd_n; pend_addr = address; end
          rd_n++;
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] pat;
    int          flip_lo, flip_n, drop_wr, drop_rd;
    logic        e_pass, e_to;
    logic [1:0]  e_err;
    logic [24:0] e_faddr;
    logic [15:0] e_fdata;
    int          e_wr, e_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic setup_model(input vec_t v);
    cur_mode = v.mode; cur_pat = v.pat; flip_lo = v.flip_lo; flip_n = v.flip_n;
    drop_wr = v.drop_wr; drop_rd = v.drop_rd; wr_n = 0; rd_n = 0;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!ready && n < 200) begin tick; n++; end
    chk("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic wait_done;
    int n = 0;
    while (!done && n < 3000) begin tick; n++; end
    chk("done", 32'(done), 32'd1);
  endtask

  task automatic run_pass(input vec_t v);
    setup_model(v);
    wait_ready;
    mode = v.mode; pattern = v.pat; start = 1'b1;
    tick;
    start = 1'b0; mode = ~v.mode; pattern = ~v.pat;
    chk("running", 32'(running), 32'd1);
    chk("done_clr", 32'(done), 32'd0);
    wait_done;
    chk("state_done", 32'(state_code), 32'd6);
    chk("pass", 32'(pass), 32'(v.e_pass));
    chk("timeout", 32'(timeout), 32'(v.e_to));
    chk("err_count", 32'(err_count), 32'(v.e_err));
    chk("first_err_addr", 32'(first_err_addr), 32'(v.e_faddr));
    chk("first_err_data", 32'(first_err_data), 32'(v.e_fdata));
    chk("writes", 32'(wr_n), 32'(v.e_wr));
    chk("reads", 32'(rd_n), 32'(v.e_rd));
    tick;
    chk("ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{2'd0, 16'h0042,  0,  0, -1, -1, 1'b1, 1'b0, 2'd0, 25'h0,      16'h0,    20, 20};
    vecs[1]  = '{2'd2, 16'h0000, 17,  1, -1, -1, 1'b0, 1'b0, 2'd1, 25'h100011, 16'h0003, 20, 20};
    vecs[2]  = '{2'd1, 16'hF0F0,  0,  0, -1, -1, 1'b1, 1'b0, 2'd0, 25'h0,      16'h0,    20, 20};
    vecs[3]  = '{2'd3, 16'h8001,  5,  1, -1, -1, 1'b0, 1'b0, 2'd1, 25'h100005, 16'h0031, 20, 20};
    vecs[4]  = '{2'd0, 16'h00A5,  2,  5, -1, -1, 1'b0, 1'b0, 2'd3, 25'h100002, 16'h00A4, 20, 20};
    vecs[5]  = '{2'd1, 16'h1234,  0,  1, -1, -1, 1'b0, 1'b0, 2'd1, 25'h100000, 16'h1235, 20, 20};
    vecs[6]  = '{2'd3, 16'h0001, 19,  1, -1, -1, 1'b0, 1'b0, 2'd1, 25'h100013, 16'h0009, 20, 20};
    vecs[7]  = '{2'd0, 16'h0042,  0,  0,  2, -1, 1'b0, 1'b1, 2'd0, 25'h0,      16'h0,     3,  0};
    vecs[8]  = '{2'd2, 16'h0000,  0,  0, -1,  4, 1'b0, 1'b1, 2'd0, 25'h0,      16'h0,    20,  5};
    vecs[9]  = '{2'd1, 16'hFFFF,  0, 20, -1, -1, 1'b0, 1'b0, 2'd3, 25'h100000, 16'hFFFE, 20, 20};
    vecs[10] = '{2'd3, 16'hA5C3,  0,  0, -1, -1, 1'b1, 1'b0, 2'd0, 25'h0,      16'h0,    20, 20};

    // Reset values and startup delay; a start during startup must be ignored
    repeat (3) tick;
    chk("rst_state", 32'(state_code), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_flags", 32'({done, pass, timeout, start_write, start_read}), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_addr", 32'(address), 32'(BASE));
    chk("rst_wdata", 32'(write_data), 32'd0);
    chk("rst_ferr", 32'(first_err_addr) | 32'(first_err_data), 32'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c == 4) start = 1'b1;
      if (c == 5) start = 1'b0;
      if (c == 9) chk("ready_c9", 32'(ready), 32'd0);
      if (c == 10) chk("ready_c10", 32'(ready), 32'd1);
    end
    repeat (3) tick;
    chk("early_start_ign", 32'(state_code), 32'd1);
    chk("early_no_req", 32'(wr_n + rd_n), 32'd0);

    for (int i = 0; i < 11; i++) run_pass(vecs[i]);

    // busy held for 5 cycles in WR_ISSUE
    v = vecs[0];
    v.pat = 16'h3C3C;
    setup_model(v);
    wait_ready;
    busy = 1'b1; mode = v.mode; pattern = v.pat; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("busy_state", 32'(state_code), 32'd2);
      chk("busy_no_wr", 32'(start_write), 32'd0);
      tick;
    end
    busy = 1'b0;
    @(negedge clk);
    chk("busy_wr_go", 32'(start_write), 32'd1);
    tick;
    chk("busy_wr_pulse", 32'(start_write), 32'd0);
    chk("busy_wr_wait", 32'(state_code), 32'd3);
    wait_done;
    chk("busy_pass", 32'(pass), 32'd1);
    chk("busy_writes", 32'(wr_n), 32'd20);

    // Asynchronous reset during the read phase, then a clean pass
    v = vecs[2];
    setup_model(v);
    wait_ready;
    mode = v.mode; pattern = v.pat; start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 0; n < 500 && rd_n < 3; n++) tick;
    chk("mid_read_reached", 32'(rd_n >= 3), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state_code), 32'd0);
    chk("mid_rst_flags", 32'({ready, running, done, pass, timeout, start_write, start_read}), 32'd0);
    chk("mid_rst_addr", 32'(address), 32'(BASE));
    tick;
    chk("mid_rst_edge", 32'({ready, running, done, start_read}), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c == 9) chk("re_ready_c9", 32'(ready), 32'd0);
      if (c == 10) chk("re_ready_c10", 32'(ready), 32'd1);
    end
    run_pass(vecs[3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
